iob_timer_sched: RTL

Multi-channel alarm scheduler that shares the 64-bit free-running cycle count of the timer peripheral among `N_CH` software-programmed alarm channels. Each channel holds a 64-bit compare value and an optional reload period. The channels raise per-channel interrupts in one-shot or periodic mode. A single shared 64-bit comparator is time-multiplexed across channels by a round-robin scan pointer. The block sits next to the timer on the CPU peripheral bus, using the same valid/addr/ready handshake, and feeds the interrupt controller.

---
 rtl/iob_timer_sched_pkg.sv | 21 ++
 rtl/iob_timer_sched_cmp.sv | 25 ++
 rtl/iob_timer_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/iob_timer_sched_pkg.sv
// Shared definitions for the alarm scheduler: register map, CTRL bit layout
// and the bus/count widths used by the top and the shared comparator.
package iob_timer_sched_pkg;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 64;

   typedef enum logic [1:0] {
      REG_CTRL   = 2'd0,
      REG_CMP_LO = 2'd1,
      REG_CMP_HI = 2'd2,
      REG_PERIOD = 2'd3
   } reg_e;

   localparam int CTRL_EN       = 0;
   localparam int CTRL_PERIODIC = 1;
   localparam int CTRL_IE       = 2;
   localparam int CTRL_PENDING  = 3;
   localparam int CTRL_OVERRUN  = 4;

endpackage

// File: rtl/iob_timer_sched_cmp.sv
// Shared 64-bit alarm comparator, time-multiplexed across channels by the
// scan pointer; computes the fire decision and the post-fire channel state.
module iob_timer_sched_cmp
   import iob_timer_sched_pkg::*;
(
   input  logic [CNT_W-1:0]  i_time_in,
   input  logic [CNT_W-1:0]  i_cmp,
   input  logic [DATA_W-1:0] i_period,
   input  logic              i_periodic,
   input  logic              i_en,
   output logic              o_fire,
   output logic [CNT_W-1:0]  o_next_cmp,
   output logic              o_next_en
);

   assign o_fire = i_en && (i_time_in >= i_cmp);

   // Periodic channels reload by a zero-extended period, wrapping mod 2^64.
   assign o_next_cmp = (o_fire && i_periodic)
                       ? i_cmp + {{(CNT_W-DATA_W){1'b0}}, i_period}
                       : i_cmp;

   assign o_next_en = o_fire ? i_periodic : i_en;

endmodule

// File: rtl/iob_timer_sched.sv
// Multi-channel alarm scheduler: per-channel compare/period registers on the
// peripheral bus, scanned round-robin against the free-running timer count.
module iob_timer_sched
   import iob_timer_sched_pkg::*;
#(
   parameter int N_CH   = 4,
   parameter int ADDR_W = $clog2(N_CH) + 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  i_time_in,
   input  logic              i_valid,
   input  logic              i_wr,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata,
   output logic              o_ready,
   output logic [N_CH-1:0]   o_irq
);

   localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

   logic [N_CH-1:0]   r_en;
   logic [N_CH-1:0]   r_periodic;
   logic [N_CH-1:0]   r_ie;
   logic [N_CH-1:0]   r_pending;
   logic [N_CH-1:0]   r_overrun;
   logic [CNT_W-1:0]  r_cmp [N_CH];
   logic [DATA_W-1:0] r_period [N_CH];
   logic [DATA_W-1:0] r_shadow;
   logic [PTR_W-1:0]  r_ptr;

   logic [ADDR_W-1:0] w_ch;
   reg_e              w_reg;
   logic [N_CH-1:0]   w_sel;
   logic [N_CH-1:0]   w_we;
   logic [N_CH-1:0]   w_hit;
   logic              w_wrAny;
   logic [CNT_W-1:0]  w_scanCmp;
   logic [DATA_W-1:0] w_scanPeriod;
   logic              w_scanPeriodic;
   logic              w_scanEn;
   logic              w_fire;
   logic [CNT_W-1:0]  w_nextCmp;
   logic              w_nextEn;
   logic [DATA_W-1:0] w_rdata;

   assign w_ch    = i_addr >> 2;
   assign w_reg   = reg_e'(i_addr[1:0]);
   assign w_wrAny = i_valid && i_wr && (|w_sel);
   assign o_irq   = r_pending & r_ie;

   // Channel indices at or above N_CH never match, so they read 0 and
   // writes to them fall through without touching any state.
   always_comb begin
      w_sel = '0;
      w_we  = '0;
      w_hit = '0;
      for (int c = 0; c < N_CH; c++) begin
         w_sel[c] = (w_ch == ADDR_W'(c));
         w_we[c]  = i_valid && i_wr && w_sel[c];
         w_hit[c] = w_fire && (r_ptr == PTR_W'(c));
      end
   end

   always_comb begin
      w_scanCmp      = '0;
      w_scanPeriod   = '0;
      w_scanPeriodic = 1'b0;
      w_scanEn       = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
         if (r_ptr == PTR_W'(c)) begin
            w_scanCmp      = r_cmp[c];
            w_scanPeriod   = r_period[c];
            w_scanPeriodic = r_periodic[c];
            w_scanEn       = r_en[c];
         end
      end
   end

   iob_timer_sched_cmp u_cmp (
      .i_time_in  (i_time_in),
      .i_cmp      (w_scanCmp),
      .i_period   (w_scanPeriod),
      .i_periodic (w_scanPeriodic),
      .i_en       (w_scanEn),
      .o_fire     (w_fire),
      .o_next_cmp (w_nextCmp),
      .o_next_en  (w_nextEn)
   );

   always_comb begin
      w_rdata = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (w_sel[c]) begin
            case (w_reg)
               REG_CTRL:   w_rdata = {{(DATA_W-5){1'b0}}, r_overrun[c], r_pending[c],
                                      r_ie[c], r_periodic[c], r_en[c]};
               REG_CMP_LO: w_rdata = r_cmp[c][DATA_W-1:0];
               REG_CMP_HI: w_rdata = r_cmp[c][CNT_W-1:DATA_W];
               default:    w_rdata = r_period[c];
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (r_ptr == PTR_W'(N_CH - 1)) begin
         r_ptr <= '0;
      end else begin
         r_ptr <= r_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_ready  <= 1'b0;
         o_rdata  <= '0;
         r_shadow <= '0;
      end else begin
         o_ready <= i_valid;
         if (i_valid && !i_wr) begin
            o_rdata <= w_rdata;
         end
         if (w_wrAny && (w_reg == REG_CMP_LO)) begin
            r_shadow <= i_wdata;
         end
      end
   end

   // Collision priority: CPU writes of en/periodic/ie, CMP_HI and PERIOD beat
   // the fire-side update, while a fire-side pending/overrun set beats W1C.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_en       <= '0;
         r_periodic <= '0;
         r_ie       <= '0;
         r_pending  <= '0;
         r_overrun  <= '0;
         for (int c = 0; c < N_CH; c++) begin
            r_cmp[c]    <= '0;
            r_period[c] <= '0;
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (w_we[c] && (w_reg == REG_CTRL)) begin
               r_en[c]       <= i_wdata[CTRL_EN];
               r_periodic[c] <= i_wdata[CTRL_PERIODIC];
               r_ie[c]       <= i_wdata[CTRL_IE];
            end else if (w_hit[c]) begin
               r_en[c] <= w_nextEn;
            end

            if (w_hit[c]) begin
               r_pending[c] <= 1'b1;
            end else if (w_we[c] && (w_reg == REG_CTRL) && i_wdata[CTRL_PENDING]) begin
               r_pending[c] <= 1'b0;
            end

            if (w_hit[c] && r_pending[c]) begin
               r_overrun[c] <= 1'b1;
            end else if (w_we[c] && (w_reg == REG_CTRL) && i_wdata[CTRL_OVERRUN]) begin
               r_overrun[c] <= 1'b0;
            end

            if (w_we[c] && (w_reg == REG_CMP_HI)) begin
               r_cmp[c] <= {i_wdata, r_shadow};
            end else if (w_hit[c]) begin
               r_cmp[c] <= w_nextCmp;
            end

            if (w_we[c] && (w_reg == REG_PERIOD)) begin
               r_period[c] <= i_wdata;
            end
         end
      end
   end

endmodule
